// File: rtl/pool2_pack_if.sv
`default_nettype none
// ============================================================================
//  Module      : pool2_pack_if
//  Description : Control, pixel-stream and result bus between the pixel
//                source / FC stage and the pool2_pack max-pool packer.
//  Revision    : 1.0  initial release
// ============================================================================
interface pool2_pack_if #(
  parameter int DATA_SIZE = 8,
  parameter int RES_W     = 400
);
  logic                 start;
  logic                 clr;
  logic [DATA_SIZE-1:0] pix_in;
  logic                 pix_vld;
  logic                 pool_busy;
  logic                 pool_done;
  logic                 ovf_err;
  logic [RES_W-1:0]     conv2_results;

  modport master (
    output start, clr, pix_in, pix_vld,
    input  pool_busy, pool_done, ovf_err, conv2_results
  );

  modport slave (
    input  start, clr, pix_in, pix_vld,
    output pool_busy, pool_done, ovf_err, conv2_results
  );
endinterface
`default_nettype wire

// File: rtl/pool2_pack.sv
`default_nettype none
// ============================================================================
//  Module      : pool2_pack
//  Description : 2x2 / stride-2 signed max pool over a raster stream of conv2
//                maps, packed into the FC stage's conv2_results vector.
//                Optional macro POOL_RELU_EN clamps negative pixels to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module pool2_pack #(
  parameter int DATA_SIZE = 8,
  parameter int MAP_DIM   = 10,
  parameter int POOL_DIM  = 5,
  parameter int NUM_MAPS  = 2
) (
  input  logic         clk,
  input  logic         rst,
  pool2_pack_if.slave  bus
);

  localparam int c_SLOTS_PER_MAP = POOL_DIM * POOL_DIM;
  localparam int c_SLOTS         = NUM_MAPS * c_SLOTS_PER_MAP;
  localparam int c_RES_W         = c_SLOTS * DATA_SIZE;
  localparam int c_CW            = (MAP_DIM > 1) ? $clog2(MAP_DIM) : 1;
  localparam int c_MW            = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1;
  localparam int c_IDXW          = (c_SLOTS > 1) ? $clog2(c_SLOTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b001,
    S_COLLECT = 3'b010,
    S_DONE    = 3'b100
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_CW-1:0]              r_col;
  logic [c_CW-1:0]              r_row;
  logic [c_MW-1:0]              r_map;
  logic signed [DATA_SIZE-1:0]  r_hold;
  logic signed [DATA_SIZE-1:0]  r_partial [POOL_DIM];
  logic [DATA_SIZE-1:0]         r_slot    [c_SLOTS];
  logic                         r_ovf;

  logic                         w_enter;
  logic                         w_accept;
  logic                         w_last_col;
  logic                         w_last_row;
  logic                         w_last_map;
  logic                         w_frame_end;
  logic                         w_slot_wr;
  logic [c_CW-1:0]              w_pidx;
  logic [c_IDXW-1:0]            w_slot_idx;
  logic signed [DATA_SIZE-1:0]  w_pix;
  logic signed [DATA_SIZE-1:0]  w_m;
  logic signed [DATA_SIZE-1:0]  w_part_sel;
  logic signed [DATA_SIZE-1:0]  w_pool;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (bus.start)  w_state_nxt = S_COLLECT;
      S_COLLECT: if (w_frame_end) w_state_nxt = S_DONE;
      // clr has priority over a coincident start, which is simply dropped
      S_DONE:    if (bus.clr)    w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  assign w_enter     = (r_state == S_IDLE) && bus.start;
  assign w_accept    = (r_state == S_COLLECT) && bus.pix_vld;
  assign w_last_col  = (r_col == c_CW'(MAP_DIM - 1));
  assign w_last_row  = (r_row == c_CW'(MAP_DIM - 1));
  assign w_last_map  = (r_map == c_MW'(NUM_MAPS - 1));
  assign w_frame_end = w_accept && w_last_col && w_last_row && w_last_map;

  // ---------------------------------------------------------------- raster counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_map <= '0;
    end else if (w_enter) begin
      r_col <= '0;
      r_row <= '0;
      r_map <= '0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col <= '0;
        if (w_last_row) begin
          r_row <= '0;
          r_map <= w_last_map ? '0 : r_map + 1'b1;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- pixel conditioning
`ifdef POOL_RELU_EN
  assign w_pix = bus.pix_in[DATA_SIZE-1] ? '0 : $signed(bus.pix_in);
`else
  assign w_pix = $signed(bus.pix_in);
`endif

  // ---------------------------------------------------------------- horizontal max
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
    end else if (w_enter) begin
      r_hold <= '0;
    end else if (w_accept && !r_col[0]) begin
      r_hold <= w_pix;
    end
  end

  assign w_m    = (r_hold > w_pix) ? r_hold : w_pix;
  assign w_pidx = r_col >> 1;

  // ---------------------------------------------------------------- vertical max partials
  generate
    for (genvar p = 0; p < POOL_DIM; p++) begin : g_part
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_partial[p] <= '0;
        end else if (w_enter) begin
          r_partial[p] <= '0;
        end else if (w_accept && !r_row[0] && r_col[0] && (w_pidx == c_CW'(p))) begin
          r_partial[p] <= w_m;
        end
      end
    end
  endgenerate

  always_comb begin
    w_part_sel = '0;
    for (int p = 0; p < POOL_DIM; p++) begin
      if (w_pidx == c_CW'(p)) w_part_sel = r_partial[p];
    end
  end

  assign w_pool    = (w_part_sel > w_m) ? w_part_sel : w_m;
  assign w_slot_wr = w_accept && r_row[0] && r_col[0];

  always_comb begin
    w_slot_idx = c_IDXW'(int'(r_map) * c_SLOTS_PER_MAP
                        + int'(r_row >> 1) * POOL_DIM
                        + int'(r_col >> 1));
  end

  // ---------------------------------------------------------------- result slots
  generate
    for (genvar k = 0; k < c_SLOTS; k++) begin : g_slot
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_slot[k] <= '0;
        end else if (w_enter) begin
          r_slot[k] <= '0;
        end else if (w_slot_wr && (w_slot_idx == c_IDXW'(k))) begin
          r_slot[k] <= w_pool;
        end
      end
    end
  endgenerate

  // Slot 0 of map 0 sits at the MSB end, matching the FC loader row order
  generate
    for (genvar k = 0; k < c_SLOTS; k++) begin : g_pack
      assign bus.conv2_results[c_RES_W-1-DATA_SIZE*k -: DATA_SIZE] = r_slot[k];
    end
  endgenerate

  // ---------------------------------------------------------------- overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (bus.pix_vld && (r_state != S_COLLECT)) begin
      r_ovf <= 1'b1;
    end
  end

  assign bus.pool_busy = (r_state == S_COLLECT);
  assign bus.pool_done = (r_state == S_DONE);
  assign bus.ovf_err   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pool2_pack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pool2_pack
//  Description : Randomized scoreboard bench for pool2_pack.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pool2_pack;

  localparam int c_NM  = 2;
  localparam int c_MD  = 10;
  localparam int c_PD  = 5;
  localparam int c_RW  = 400;

  logic clk;
  logic rst;

  pool2_pack_if #(.DATA_SIZE(8), .RES_W(c_RW)) bus ();

  pool2_pack #(
    .DATA_SIZE(8),
    .MAP_DIM  (c_MD),
    .POOL_DIM (c_PD),
    .NUM_MAPS (c_NM)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [7:0] frame [c_NM][c_MD][c_MD];
  logic [c_RW-1:0]   sb_q [$];
  logic [c_RW-1:0]   last_exp;
  logic              prev_done;
  int                n_cmp = 0;
  int                n_err = 0;

  task automatic chk(input string name, input logic [c_RW-1:0] act, input logic [c_RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic signed [7:0] cond(input logic signed [7:0] v);
`ifdef POOL_RELU_EN
    return (v < 0) ? 8'sd0 : v;
`else
    return v;
`endif
  endfunction

  // Reference: each output is simply the largest of its 2x2 input window
  function automatic logic [c_RW-1:0] model();
    logic [c_RW-1:0]   res;
    logic signed [7:0] best;
    logic signed [7:0] v;
    res = '0;
    for (int n = 0; n < c_NM; n++)
      for (int i = 0; i < c_PD; i++)
        for (int j = 0; j < c_PD; j++) begin
          best = cond(frame[n][2*i][2*j]);
          for (int d = 1; d < 4; d++) begin
            v = cond(frame[n][2*i + d/2][2*j + d%2]);
            if (v > best) best = v;
          end
          res[c_RW-1 - 8*(n*c_PD*c_PD + i*c_PD + j) -: 8] = best;
        end
    return res;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // gap_mode: 0 back-to-back, 1 strict toggle, 2 random gaps
  task automatic run_frame(input int gap_mode);
    last_exp = model();
    sb_q.push_back(last_exp);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    @(negedge clk);
    chk("busy_on_start", bus.pool_busy, 1);
    #4;
    for (int n = 0; n < c_NM; n++)
      for (int r = 0; r < c_MD; r++)
        for (int c = 0; c < c_MD; c++) begin
          bus.pix_vld = 1'b1;
          bus.pix_in  = frame[n][r][c];
          if (n == c_NM-1 && r == c_MD-1 && c == c_MD-1) begin
            @(negedge clk);
            chk("done_before_last", bus.pool_done, 0);
            cyc();
            bus.pix_vld = 1'b0;
          end else begin
            cyc();
            bus.pix_vld = 1'b0;
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0)) cyc();
          end
        end
    @(negedge clk);
    chk("done_after_last", bus.pool_done, 1);
    chk("busy_after_last", bus.pool_busy, 0);
    #4;
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    cyc();
    bus.clr = 1'b0;
    @(negedge clk);
    chk("done_after_clr", bus.pool_done, 0);
    #4;
  endtask

  task automatic fill_random();
    for (int n = 0; n < c_NM; n++)
      for (int r = 0; r < c_MD; r++)
        for (int c = 0; c < c_MD; c++)
          frame[n][r][c] = 8'($urandom);
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int n = 0; n < c_NM; n++)
      for (int r = 0; r < c_MD; r++)
        for (int c = 0; c < c_MD; c++)
          frame[n][r][c] = v;
  endtask

  // Monitor: compare the packed result whenever pool_done rises
  always @(negedge clk) begin
    if (!rst && bus.pool_done && !prev_done) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected_done: got result %h expected no frame", bus.conv2_results);
      end else begin
        chk("sb_results", bus.conv2_results, sb_q.pop_front());
      end
    end
    prev_done <= bus.pool_done;
  end

  initial begin
    logic [c_RW-1:0] fill;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.clr     = 1'b0;
    bus.pix_in  = '0;
    bus.pix_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.pool_busy, 0);
    chk("rst_done", bus.pool_done, 0);
    chk("rst_ovf", bus.ovf_err, 0);
    chk("rst_results", bus.conv2_results, '0);
    #4;

    // Ramp pattern, map1 offset by 100 with signed wrap
    for (int n = 0; n < c_NM; n++)
      for (int r = 0; r < c_MD; r++)
        for (int c = 0; c < c_MD; c++)
          frame[n][r][c] = 8'(r*10 + c + n*100);
    run_frame(0);
    fill = bus.conv2_results;
    chk("ramp_slot00", fill[399:392], 8'd11);
    chk("ramp_slot44", fill[399-8*24 -: 8], 8'd99);
    do_clr();

    // All -5
    fill_const(8'hFB);
    run_frame(0);
`ifdef POOL_RELU_EN
    chk("neg_const", bus.conv2_results, '0);
`else
    chk("neg_const", bus.conv2_results, {50{8'hFB}});
`endif
    do_clr();

    // Toggled valid, then overflow while done
    fill_random();
    run_frame(1);
    bus.pix_vld = 1'b1;
    bus.pix_in  = 8'h7F;
    repeat (3) cyc();
    bus.pix_vld = 1'b0;
    @(negedge clk);
    chk("frozen_results", bus.conv2_results, last_exp);
    chk("ovf_set", bus.ovf_err, 1);
    #4;
    do_clr();
    chk("busy_after_clr", bus.pool_busy, 0);

    // Abort mid-frame with reset
    fill_random();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int p = 0; p < 57; p++) begin
      bus.pix_vld = 1'b1;
      bus.pix_in  = 8'($urandom);
      cyc();
    end
    bus.pix_vld = 1'b0;
    rst = 1'b1;
    #2;
    chk("async_rst_busy", bus.pool_busy, 0);
    chk("async_rst_ovf", bus.ovf_err, 0);
    chk("async_rst_results", bus.conv2_results, '0);
    cyc();
    rst = 1'b0;
    cyc();
    fill_const(8'h12);
    run_frame(0);
    chk("fresh_const", bus.conv2_results, {50{8'h12}});
    chk("fresh_ovf", bus.ovf_err, 0);

    // start and clr together in DONE: clr wins
    bus.start = 1'b1;
    bus.clr   = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.clr   = 1'b0;
    @(negedge clk);
    chk("startclr_busy", bus.pool_busy, 0);
    chk("startclr_done", bus.pool_done, 0);
    #4;
    cyc();
    @(negedge clk);
    chk("startclr_busy_later", bus.pool_busy, 0);
    #4;

    for (int f = 0; f < 3; f++) begin
      fill_random();
      run_frame(2);
      do_clr();
    end

    repeat (3) cyc();
    chk("sb_empty", 400'(sb_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
